// File: rtl/regfile_reader.sv
// Two-read / one-write register file with write-to-read bypass and a
// per-register pending-write scoreboard that raises stall while a consumer
// reads a register whose long-latency value has not yet arrived.
// Register 0 is hardwired to zero and never pends.
module regfile_reader #(
  parameter int unsigned MAX_LENGTH = 32,
  parameter int unsigned WIDTH      = MAX_LENGTH,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enabled,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_value,
  input  logic              read_en_a,
  input  logic [ADDR_W-1:0] read_addr_a,
  output logic [WIDTH-1:0]  read_value_a,
  input  logic              read_en_b,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  read_value_b,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              stall,
  output logic [DEPTH-1:0]  pend_vec
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             wr_hits_a;
  logic             wr_hits_b;
  logic             hazard_a;
  logic             hazard_b;

  // Storage update: reset clears everything, register 0 never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_enabled && (write_addr != '0)) begin
      mem_q[write_addr] <= write_value;
    end
  end

  // Pending next state: set is applied after clear so a newer producer wins
  always_comb begin
    pend_d = pend_q;
    if (write_enabled) begin
      pend_d[write_addr] = 1'b0;
    end
    if (pend_set) begin
      pend_d[pend_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Pending register
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Read ports with same-cycle write bypass
  always_comb begin
    wr_hits_a = write_enabled && (write_addr == read_addr_a);
    wr_hits_b = write_enabled && (write_addr == read_addr_b);
    if (read_addr_a == '0) begin
      read_value_a = '0;
    end else if (wr_hits_a) begin
      read_value_a = write_value;
    end else begin
      read_value_a = mem_q[read_addr_a];
    end
    if (read_addr_b == '0) begin
      read_value_b = '0;
    end else if (wr_hits_b) begin
      read_value_b = write_value;
    end else begin
      read_value_b = mem_q[read_addr_b];
    end
  end

  // Hazard detection: a matching write this cycle resolves through the bypass
  always_comb begin
    hazard_a = read_en_a && (read_addr_a != '0) && pend_q[read_addr_a] && !wr_hits_a;
    hazard_b = read_en_b && (read_addr_b != '0) && pend_q[read_addr_b] && !wr_hits_b;
    stall    = hazard_a || hazard_b;
  end

  assign pend_vec = pend_q;

endmodule
